// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage load/store unit in front of a word-organised data
// RAM. It turns byte-addressed requests into word-indexed RAM accesses, extracts
// and extends sub-word load data, and reports AdEL/AdES misalignment.
//
// Build option MAU_SUBWORD_EN:
//   defined   - byte/half loads with extension, sub-word stores as a two-cycle
//               read-modify-write (IDLE -> MERGE) that stalls the pipeline once.
//   undefined - every request is a word access, stall is tied low.
//
// The RAM samples address and data on the falling edge, so ram_dout is
// already valid by the rising edge that ends the cycle.
module mem_access_unit #(
  parameter int WORD_AW = 30
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic        flush,
  output logic        ram_we,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_din,
  input  logic [31:0] ram_dout,
  output logic [31:0] load_data,
  output logic        stall,
  output logic        exc_adel,
  output logic        exc_ades,
  output logic [31:0] bad_vaddr
);

  logic [WORD_AW-1:0] req_word;
  logic               misaligned;
  logic               live;

  assign req_word = req_addr[WORD_AW+1:2];

  // A request may have side effects only out of reset, valid, unflushed and aligned.
  assign live      = rst_n & req_valid & ~flush & ~misaligned;

  // Exception flags are combinational and are forced low while in reset.
  assign exc_adel  = rst_n & req_valid & ~req_we & misaligned;
  assign exc_ades  = rst_n & req_valid &  req_we & misaligned;
  assign bad_vaddr = (exc_adel | exc_ades) ? req_addr : 32'h0;

`ifdef MAU_SUBWORD_EN

  typedef enum logic {IDLE, MERGE} state_e;

  state_e             state_q, state_d;
  logic [31:0]        old_q;
  logic [WORD_AW-1:0] addr_q;
  logic [1:0]         lane_q;
  logic               half_q;
  logic [15:0]        wdata_q;
  logic               capture;
  logic [31:0]        merged;
  logic [7:0]         ld_byte;
  logic [15:0]        ld_half;

  // Alignment rule depends on the access size; size 11 behaves as a word.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    misaligned = 1'b0;
    case (req_size)
      2'b00:   misaligned = 1'b0;
      2'b01:   misaligned = req_addr[0];
      default: misaligned = |req_addr[1:0];
    endcase
  end

  // State register plus the old word and store operands captured for MERGE.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (!rst_n) begin
      state_q <= IDLE;
      old_q   <= '0;
      addr_q  <= '0;
      lane_q  <= '0;
      half_q  <= 1'b0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (capture) begin
        old_q   <= ram_dout;
        addr_q  <= req_word;
        lane_q  <= req_addr[1:0];
        half_q  <= (req_size == 2'b01);
        wdata_q <= req_wdata[15:0];
      end
    end
  end

  // Replace the addressed byte or half of the captured word with the store data.
  always_comb begin
    merged = old_q;
    if (half_q) begin
      merged[{lane_q[1], 4'b0000} +: 16] = wdata_q;
    end else begin
      merged[{lane_q, 3'b000} +: 8] = wdata_q[7:0];
    end
  end

  // Little-endian lane extraction with sign or zero extension for sub-word loads.
  always_comb begin
    ld_byte = ram_dout[{req_addr[1:0], 3'b000} +: 8];
    ld_half = ram_dout[{req_addr[1], 4'b0000} +: 16];
    case (req_size)
      2'b00:   load_data = {{24{req_signed & ld_byte[7]}}, ld_byte};
      2'b01:   load_data = {{16{req_signed & ld_half[15]}}, ld_half};
      default: load_data = ram_dout;
    endcase
  end

  // Next state and RAM controls; MERGE ignores req_* since the pipeline holds the instruction.
  always_comb begin
    state_d  = state_q;
    capture  = 1'b0;
    ram_we   = 1'b0;
    stall    = 1'b0;
    ram_addr = {{(32-WORD_AW){1'b0}}, req_word};
    ram_din  = req_wdata;
    case (state_q)
      IDLE: begin
        if (live && req_we) begin
          if (req_size[1]) begin
            ram_we = 1'b1;
          end else begin
            stall   = 1'b1;
            capture = 1'b1;
            state_d = MERGE;
          end
        end
      end
      MERGE: begin
        ram_addr = {{(32-WORD_AW){1'b0}}, addr_q};
        ram_din  = merged;
        ram_we   = rst_n & ~flush;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

`else

  logic unused_inputs;

  // Word-only build: no state, every access must be word aligned.
  assign misaligned    = |req_addr[1:0];
  assign ram_we        = live & req_we;
  assign stall         = 1'b0;
  assign ram_addr      = {{(32-WORD_AW){1'b0}}, req_word};
  assign ram_din       = req_wdata;
  assign load_data     = ram_dout;
  assign unused_inputs = ^{clk, req_size, req_signed};

`endif

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

MEM-stage load/store unit sitting directly upstream of the word-organised data RAM. It takes byte-addressed load/store requests from the pipeline and converts them into word-indexed RAM accesses. It extracts and sign- or zero-extends sub-word load data, and performs sub-word stores as a two-cycle read-modify-write that stalls the pipeline. It also reports misaligned-address exceptions (AdEL/AdES) to the interrupt/exception logic.

## Interface
- `WORD_AW`, default 30: width of the word address driven to the RAM (byte address bits [31:2]).
- `clk`, in, 1: pipeline clock. All unit state is updated on the rising edge; the RAM samples on the falling edge.
- `rst_n`, in, 1: reset, asynchronous, active-low.
- `req_valid`, in, 1: a memory instruction is present in MEM this cycle.
- `req_we`, in, 1: 1 = store, 0 = load.
- `req_size`, in, 2: access size. 00 = byte, 01 = half, 10 = word, 11 = treated as word.
- `req_signed`, in, 1: sign-extend sub-word loads (lb/lh). 0 means zero-extend (lbu/lhu).
- `req_addr`, in, 32: byte address.
- `req_wdata`, in, 32: store data, right-aligned.
- `flush`, in, 1: pipeline flush from the exception unit.
- `ram_we`, out, 1: RAM write enable.
- `ram_addr`, out, 32: word address, `{2'b00, addr[31:2]}`.
- `ram_din`, out, 32: RAM write data.
- `ram_dout`, in, 32: RAM read data, valid after the falling edge of the cycle in which `ram_addr` is presented.
- `load_data`, out, 32: extracted load result.
- `stall`, out, 1: freezes IF through MEM for this cycle.
- `exc_adel`, out, 1: misaligned load.
- `exc_ades`, out, 1: misaligned store.
- `bad_vaddr`, out, 32: faulting byte address (BadVAddr).

## Operation
- **FSM states:** IDLE and MERGE.
- **Misalignment:**
  - half access with `addr[0]` = 1 is misaligned;
  - word access with `addr[1:0]` ≠ 0 is misaligned;
  - `exc_adel` = valid & !we & misaligned; `exc_ades` = valid & we & misaligned.
  - A misaligned access never asserts `ram_we` or `stall`.
  - `bad_vaddr` = `req_addr` whenever either exception flag is high, else 0.
- **Loads (IDLE, aligned):**
  - `ram_addr` is driven from `req_addr`; `ram_we` = 0; no stall.
  - `load_data` selects the byte lane (`addr[1:0]` × 8) or half lane (`addr[1]` × 16), little-endian, and extends per `req_signed`.
  - Word loads pass `ram_dout` through unchanged.
- **Word store (IDLE, aligned):** `ram_we` = 1, `ram_din` = `req_wdata`, single cycle, no stall.
- **Sub-word store (IDLE, aligned, !flush):**
  - `ram_we` = 0 and `stall` = 1.
  - At the rising edge, capture `ram_dout` (old word), the word address, lane, size and `req_wdata`, then go to MERGE.
- **MERGE:**
  - `ram_addr` = captured address; `ram_we` = !flush; `stall` = 0.
  - `ram_din` = old word with the addressed byte or half replaced by `wdata[7:0]` or `wdata[15:0]`.
  - Next state is always IDLE. `req_*` inputs are ignored in MERGE because the pipeline still holds the same instruction.
- **Flush:**
  - In IDLE, all side effects are suppressed: no `ram_we`, no stall, no state change. Exception flags still follow the inputs.
  - In MERGE, the write is aborted and the FSM returns to IDLE.
- **`req_valid` = 0:** `ram_we` = 0, `stall` = 0, exception flags 0, `ram_addr` still follows `req_addr`.

## Timing
- **Reset (`rst_n` low):**
  - State goes to IDLE and captured registers go to 0 immediately.
  - `ram_we`, `stall`, `exc_adel`, `exc_ades` and `bad_vaddr` are forced to 0 while reset is asserted.
- **Reset mid-RMW:** the MERGE write is dropped; no partial word is ever written.
- **Load latency:** 0 stall cycles. `load_data` is valid in the second half of the cycle after `ram_dout` settles, in time for the MEM/WB register.
- **Word store:** 1 cycle. Sub-word store: 2 cycles, with `stall` high in the first only.
- **Back-to-back:** a sub-word store immediately following another store to the same word sees the earlier write, because the RAM wrote on the prior falling edge.
- **Exception flags:** combinational, same cycle as the request.

## Configuration
- `MAU_SUBWORD_EN` defined:
  - full byte/half support and the MERGE state as described above.
- `MAU_SUBWORD_EN` undefined:
  - every request is handled as a word access; no MERGE state, `stall` tied to 0;
  - alignment is checked on `addr[1:0]` for all sizes;
  - `load_data` = `ram_dout`.

## Test plan
- **Word store/load:** sw 0xDEADBEEF to 0x8, then lw 0x8 → `ram_we` pulses 1 cycle at `ram_addr` 2; `load_data` 0xDEADBEEF; `stall` never asserted.
- **Byte RMW store:** sb 0x5A to 0x9 over word 0x11223344 → `stall` high 1 cycle, then `ram_din` 0x11225A44 in MERGE; lw 0x8 returns 0x11225A44.
- **Sub-word load extension:** word 0x80FF7F01:
  - lb 0xA → 0xFFFFFFFF;
  - lbu 0xA → 0x000000FF;
  - lh 0xA → 0xFFFF80FF;
  - lhu 0x8 → 0x00007F01.
- **Misaligned accesses:**
  - lw 0x6 → `exc_adel` = 1, `bad_vaddr` 0x6, `ram_we` 0;
  - sh 0x3 → `exc_ades` = 1, no write, no stall.
- **Flush during MERGE:** sh 0x4 with `flush` raised in the MERGE cycle → `ram_we` stays 0, memory unchanged, FSM back in IDLE the next cycle.
- **Reset mid-RMW:** `rst_n` dropped during MERGE → `ram_we` 0 immediately, state IDLE, word unchanged.
